// File: rtl/full_adder_pkg.sv
// Shared constants and the golden reference sum for the full_adder family.
package full_adder_pkg;

  localparam int unsigned FA_DEFAULT_WIDTH = 1;
  localparam int unsigned FA_MAX_WIDTH     = 64;

  typedef logic [FA_MAX_WIDTH-1:0] fa_operand_t;
  typedef logic [FA_MAX_WIDTH:0]   fa_result_t;

  // Exact (width+1)-bit unsigned sum; bits above position `width` are cleared
  // so callers can truncate to {carry, sum} of any legal width.
  function automatic fa_result_t fa_ref(
    input fa_operand_t a,
    input fa_operand_t b,
    input logic        c_in,
    input int unsigned width
  );
    fa_result_t r;
    r = fa_result_t'(a) + fa_result_t'(b) + fa_result_t'(c_in);
    for (int unsigned i = 0; i <= FA_MAX_WIDTH; i++) begin
      if (i > width) begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full-adder cell: XOR sum and majority carry.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder built from full_adder_cell, with an optional output register.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH      = FA_DEFAULT_WIDTH,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "full_adder: WIDTH must be in 1..64");
  end

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    full_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (w_carry[i]),
      .sum   (w_sum[i]),
      .c_out (w_carry[i+1])
    );
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum   <= '0;
        r_c_out <= 1'b0;
      end else begin
        r_sum   <= w_sum;
        r_c_out <= w_carry[WIDTH];
      end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;
  end else begin : g_comb
    // clk and rst are intentionally unused in combinational mode.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, rst};
    assign sum   = w_sum;
    assign c_out = w_carry[WIDTH];
  end

  always_comb begin
    if (!$isunknown({a, b, c_in})) begin
      assert ({w_carry[WIDTH], w_sum} ==
              (WIDTH+1)'(fa_ref(FA_MAX_WIDTH'(a), FA_MAX_WIDTH'(b), c_in, WIDTH)));
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: 1-bit and 8-bit registered adders plus a 4-bit combinational one.
module tb_full_adder;
  import full_adder_pkg::*;

  logic       clk;
  logic       rst;
  logic       a1, b1, ci1, s1, co1;
  logic [7:0] a8, b8, s8;
  logic       ci8, co8;
  logic [3:0] a4, b4, s4;
  logic       ci4, co4;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  typedef struct {
    string      nm;
    logic [8:0] exp;
  } sb_t;

  typedef struct {
    logic a, b, c, s, co;
  } tt_t;

  typedef struct {
    logic [3:0] a, b;
    logic       c;
    logic [3:0] s;
    logic       co;
  } cv_t;

  sb_t q1[$];
  sb_t q8[$];

  full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(ci1), .sum(s1), .c_out(co1)
  );
  full_adder #(.WIDTH(8), .REGISTERED(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(ci8), .sum(s8), .c_out(co8)
  );
  full_adder #(.WIDTH(4), .REGISTERED(1'b0)) u_c4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c_in(ci4), .sum(s4), .c_out(co4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    fa_result_t t;
    t = fa_ref(FA_MAX_WIDTH'(x), FA_MAX_WIDTH'(y), c, 8);
    return t[8:0];
  endfunction

  // Drive one cycle of stimulus, queue the expectations, then compare after the edge.
  task automatic step(input logic r,
                      input logic ia1, input logic ib1, input logic ic1, input logic [1:0] e1,
                      input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8,
                      input logic [8:0] e8, input string nm);
    sb_t e;
    rst = r;
    a1 = ia1; b1 = ib1; ci1 = ic1;
    a8 = ia8; b8 = ib8; ci8 = ic8;
    e.nm = {nm, "/w1"}; e.exp = {7'd0, e1}; q1.push_back(e);
    e.nm = {nm, "/w8"}; e.exp = e8;         q8.push_back(e);
    @(posedge clk);
    #1;
    e = q1.pop_front();
    check(e.nm, {7'd0, co1, s1}, e.exp);
    e = q8.pop_front();
    check(e.nm, {co8, s8}, e.exp);
  endtask

  initial begin
    tt_t         tt[8];
    cv_t         cv[5];
    logic [7:0]  ra, rb;
    logic        rc;
    logic        x, y, z;

    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    cv[0] = '{4'h9, 4'h8, 1'b1, 4'h2, 1'b1};
    cv[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    cv[2] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    cv[3] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
    cv[4] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0};

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    a8 = '0; b8 = '0; ci8 = 1'b0;
    a4 = '0; b4 = '0; ci4 = 1'b0;

    // Reset held two edges with all-ones inputs, then the first real result.
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 8'hAA, 8'h55, 1'b1, 9'h000, "rst_hold0");
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 8'hAA, 8'h55, 1'b1, 9'h000, "rst_hold1");
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 8'hFF, 8'h00, 1'b1, 9'h100, "rst_release_wrap");

    for (int unsigned i = 0; i < 8; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      step(1'b0, tt[i].a, tt[i].b, tt[i].c, {tt[i].co, tt[i].s},
           ra, rb, rc, ref8(ra, rb, rc), $sformatf("truth%0d", i));
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h12, 8'h34, 1'b0, 9'h046, "b2b_first");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h80, 8'h80, 1'b0, 9'h100, "b2b_second");
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b1, 9'h1FF, "all_ones");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 9'h000, "all_zeros");

    // Reset on the same edge as valid inputs: result suppressed, appears after release.
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 8'h7F, 8'h01, 1'b0, 9'h000, "mid_rst");
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 8'h7F, 8'h01, 1'b0, 9'h080, "after_rst");

    for (int unsigned i = 0; i < 16; i++) begin
      x = 1'($urandom); y = 1'($urandom); z = 1'($urandom);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      step(1'b0, x, y, z, 2'(int'(x) + int'(y) + int'(z)),
           ra, rb, rc, ref8(ra, rb, rc), $sformatf("rand%0d", i));
    end

    for (int unsigned i = 0; i < 5; i++) begin
      a4 = cv[i].a; b4 = cv[i].b; ci4 = cv[i].c;
      #1;
      check($sformatf("comb%0d", i), {4'd0, co4, s4}, {4'd0, cv[i].co, cv[i].s});
      if (i == 0) begin
        rst = 1'b1;
        #1;
        check("comb_rst_hi", {4'd0, co4, s4}, {4'd0, cv[i].co, cv[i].s});
        rst = 1'b0;
        #1;
        check("comb_rst_lo", {4'd0, co4, s4}, {4'd0, cv[i].co, cv[i].s});
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
